// File: rtl/seg_pkg.sv
// Shared segment encodings for the multiplexed seven-segment scanner.
// All patterns are active-low, ordered {a,b,c,d,e,f,g} (plus dp for 8-bit values).
package seg_pkg;

    typedef logic [3:0] code_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

    // Any code from B to F decodes to a blank digit.
    localparam code_t CODE_BLANK = 4'hF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to active-low {a..g} segment decoder.
module seg_decode
    import seg_pkg::*;
(
    input  code_t      code,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: the default arm assigns seg on every path, so no latch is inferred.
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver with a double-buffered digit register,
// frame-aligned updates, leading-zero blanking and an anti-ghosting blank slot.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg_output,
    output logic                  frame_done
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_digits, act_digits;
    logic [DIGITS-1:0]   shadow_dp, act_dp;
    logic                shadow_blz, act_blz;
    logic                pending;

    logic [CNT_W-1:0]    scan_cnt;
    logic [IDX_W-1:0]    idx;

    logic                slot_last;
    logic                frame_wrap;
    logic [DIGITS-1:0]   lz_blank;
    code_t               sel_code;
    logic                sel_dp;
    logic [6:0]          sel_seg;

    assign slot_last  = (scan_cnt == CNT_LAST);
    assign frame_wrap = enable && slot_last && (idx == IDX_LAST);

    // NOTE: both register sets are reset so a mid-frame reset cannot leave stale pending data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blz    <= 1'b0;
            pending       <= 1'b0;
        end else if (load) begin
            // NOTE: state registers use non-blocking assignment so every block sees pre-edge values.
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_blz    <= blank_lz;
            pending       <= 1'b1;
        end else if (frame_wrap) begin
            pending       <= 1'b0;
        end
    end

    // The wrap copies the shadow content that existed before this edge, even if load is high now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_digits <= '0;
            act_dp     <= '0;
            act_blz    <= 1'b0;
        end else if (frame_wrap && pending) begin
            act_digits <= shadow_digits;
            act_dp     <= shadow_dp;
            act_blz    <= shadow_blz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (enable) begin
            if (slot_last) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Walk down from the most significant digit while codes stay zero; digit 0 is never blanked.
    always_comb begin : lz_scan
        logic run;
        lz_blank = '0;
        run      = act_blz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run         = run && (act_digits[4*k +: 4] == 4'h0);
            lz_blank[k] = run;
        end
    end

    assign sel_code = lz_blank[idx] ? CODE_BLANK : act_digits[4*idx +: 4];
    assign sel_dp   = act_dp[idx];

    seg_decode u_decode (
        .code (sel_code),
        .seg  (sel_seg)
    );

    // an and segments are registered from the same index so they always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '0;
            seg_output <= SEG_OFF;
            frame_done <= 1'b0;
        end else if (enable) begin
            an         <= DIGITS'(1) << idx;
            seg_output <= (scan_cnt == '0) ? SEG_OFF : {sel_seg, ~sel_dp};
            frame_done <= frame_wrap;
        end else begin
            an         <= '0;
            seg_output <= SEG_OFF;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues expected {an,seg} per lit slot,
// a negedge monitor pops and compares on the second cycle of every digit slot.
module tb_seg_scan_mux;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110;
    localparam logic [6:0] SB = 7'b1111111;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic                load;
    logic [4*DIGITS-1:0] digits_in;
    logic [DIGITS-1:0]   dp_in;
    logic                blank_lz;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg_output;
    logic                frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg_output (seg_output),
        .frame_done (frame_done)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q[$];
    logic        mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    // Monitor: a new non-zero an marks a slot's first cycle (must be blank); the next cycle is compared.
    logic [DIGITS-1:0] an_q  = '0;
    logic              armed = 1'b0;

    always @(negedge clk) begin
        logic        new_slot;
        logic [11:0] e;
        new_slot = (an != '0) && (an != an_q);
        if (mon_en && new_slot) check("ghost_blank", {24'd0, seg_output}, 32'hFF);
        if (mon_en && armed) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
            check("slot", {20'd0, an, seg_output}, {20'd0, e});
        end
        armed <= new_slot;
        an_q  <= an;
    end

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dp);
        exp_q.push_back({4'b0001, s0, ~dp[0]});
        exp_q.push_back({4'b0010, s1, ~dp[1]});
        exp_q.push_back({4'b0100, s2, ~dp[2]});
        exp_q.push_back({4'b1000, s3, ~dp[3]});
    endtask

    task automatic wait_frame();
        int t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (frame_done !== 1'b1) check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic blz);
        digits_in = d;
        dp_in     = dp;
        blank_lz  = blz;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Load at a frame boundary, then check the whole following frame.
    task automatic show_frame(input logic [15:0] d, input logic [3:0] dp, input logic blz,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        wait_frame();
        do_load(d, dp, blz);
        wait_frame();
        push_frame(s3, s2, s1, s0, dp);
        mon_en = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_lz  = 1'b0;

        // Reset state and first slot after release
        repeat (2) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'd0);
        check("rst_seg", {24'd0, seg_output}, 32'hFF);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("start_an", {28'd0, an}, 32'h1);
        check("start_seg_ghost", {24'd0, seg_output}, 32'hFF);
        @(negedge clk);
        check("start_an_hold", {28'd0, an}, 32'h1);
        check("start_seg_zero", {24'd0, seg_output}, 32'h03);

        // Test 1: basic scan of 1234 and frame period
        show_frame(16'h1234, 4'b0000, 1'b0, S1, S2, S3, S4);
        wait_frame();
        @(negedge clk);
        check("frame_done_width", {31'd0, frame_done}, 32'd0);
        t = 1;
        while (frame_done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("frame_period", t, 16);

        // Test 2: leading-zero blanking
        show_frame(16'h0070, 4'b0000, 1'b1, SB, SB, S7, S0);
        show_frame(16'h0705, 4'b0000, 1'b1, SB, S7, S0, S5);
        show_frame(16'h0000, 4'b1000, 1'b1, SB, SB, SB, S0);

        // Test 4: decimal point, dash and code-blank
        show_frame(16'hE3A6, 4'b0100, 1'b0, SB, S3, SD, S6);

        // Test 3a: two loads in one frame, last wins at the wrap
        wait_frame();
        push_frame(SB, S3, SD, S6, 4'b0100);
        push_frame(S5, S6, S7, S8, 4'b0000);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        do_load(16'h5678, 4'b0000, 1'b0);
        drain();

        // Test 3b: load on the wrap cycle is deferred while older pending data transfers
        wait_frame();
        push_frame(S5, S6, S7, S8, 4'b0000);
        push_frame(S4, S3, S2, S1, 4'b0000);
        push_frame(S9, S8, S0, S7, 4'b0000);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        do_load(16'h4321, 4'b0000, 1'b0);
        repeat (11) @(negedge clk);
        do_load(16'h9807, 4'b0000, 1'b0);
        drain();

        // Test 5: enable dropped mid-slot for 10 cycles
        wait_frame();
        repeat (6) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("disabled_outputs", {19'd0, an, seg_output, frame_done}, {19'd0, 4'b0000, 8'hFF, 1'b0});
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_an", {28'd0, an}, 32'h2);
        check("resume_seg", {24'd0, seg_output}, 32'h03);
        t = 1;
        while (frame_done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("resume_to_wrap", t, 10);

        // Test 6: asynchronous reset with pending data
        wait_frame();
        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", {28'd0, an}, 32'd0);
        check("async_rst_seg", {24'd0, seg_output}, 32'hFF);
        check("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frame();
        push_frame(S0, S0, S0, S0, 4'b0000);
        mon_en = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
